slow_tick_bcd_counter: RTL and testbench
========================================

Name: slow_tick_bcd_counter

Overview:
Consumes the 4 Hz square wave from the slow-clock divider and drives a DIGITS-wide BCD up/down counter for the board display. slow_clk_i is treated as data, never as a clock. It is synchronised into the 100 MHz domain and edge-detected. Each accepted edge advances the counter under run/direction/load/clear control. Sits between the divider and the 7-segment display driver.

Parameters:
DIGITS, 4, number of BCD digits; counter range 0 to 10^DIGITS-1
BOTH_EDGES, 0, 0 = count on rising edges of slow_clk_i only; 1 = count on both edges (8 Hz effective)

Ports:
clk_i  in  1  100 MHz system clock
rst_i  in  1  synchronous, active-high reset
slow_clk_i  in  1  4 Hz square wave from divider; asynchronous-to-logic data
run_i  in  1  level; 1 = accepted ticks advance the counter
up_i  in  1  1 = count up, 0 = count down; sampled on the tick cycle
load_i  in  1  one-cycle pulse; load load_val_i
load_val_i  in  4*DIGITS  BCD load value; digit i at bits [4i+3:4i]
clear_i  in  1  one-cycle pulse; counter to 0
bcd_o  out  4*DIGITS  current BCD count, registered
tick_o  out  1  one-cycle pulse per detected slow_clk_i edge
wrap_o  out  1  one-cycle pulse on a wrap: max->0 going up, 0->max going down
load_err_o  out  1  one-cycle pulse when a load is rejected (any digit > 9)

Behaviour:
- All state is updated on posedge clk_i. rst_i has the highest priority.
- Reset values: bcd_o=0, tick_o=0, wrap_o=0, load_err_o=0, synchroniser flops s1/s2/s3=0, arm counter=0.
- Synchroniser: s1<=slow_clk_i, s2<=s1, s3<=s2.
- Edge detect: edge = s2&~s3 when BOTH_EDGES=0; edge = s2^s3 when BOTH_EDGES=1.
- Arming: edge is masked until 3 clk_i cycles after rst_i deasserts. A slow_clk_i that is already high at reset release therefore produces no tick.
- Latency: slow_clk_i is first sampled high at edge k. tick_o and any resulting bcd_o change become visible after edge k+2.
- Input constraint: minimum slow_clk_i high/low width is 3 clk_i cycles. No glitch filtering.
- tick_o pulses on every unmasked edge, regardless of run_i, load_i or clear_i.
- Per-cycle priority: rst_i > clear_i > valid load_i > count.
  - clear_i: bcd_o<=0. A coincident tick is dropped and wrap_o stays 0.
  - load_i with all digits <= 9: bcd_o<=load_val_i. A coincident tick is dropped.
  - load_i with any digit > 9: load ignored, load_err_o pulses the next cycle, bcd_o unchanged by the load. A coincident tick still counts if run_i=1.
  - count: on a tick with run_i=1, bcd_o increments or decrements by 1 in BCD.
- BCD arithmetic: ripple carry/borrow digit by digit.
  - Up: digit 9 -> 0 with carry to the next digit.
  - Down: digit 0 -> 9 with borrow to the next digit.
  - Full-range wraps: all-9s up -> all-0s with wrap_o=1; all-0s down -> all-9s with wrap_o=1.
  - bcd_o never holds a non-BCD digit.
- wrap_o, tick_o and load_err_o are registered and each high for exactly 1 cycle per event.
- run_i=0 freezes the count. Edges are still tracked, so no burst of ticks occurs when run_i returns to 1.
- Reset mid-operation: all state returns to reset values within 1 cycle, and arming restarts.

Test Plan:
1. rst_i released while slow_clk_i=1, held high for 20 cycles -> tick_o never asserts, bcd_o=0x0000. Next rising edge -> exactly one tick_o.
2. run_i=1, up_i=1, 4 rising edges (10-cycle high / 10-cycle low periods) -> bcd_o 0x0001..0x0004. Each update appears 2 cycles after the first high sample; 4 tick_o pulses.
3. Load 0x9998, up, 2 ticks -> 0x9999 then 0x0000, wrap_o pulses on the second tick only. Then up_i=0, 1 tick -> 0x9999 with wrap_o pulse.
4. Load 0x1299, up, 1 tick -> 0x1300. Load 0x0100, down, 1 tick -> 0x0099. No wrap_o in either case.
5. load_i with load_val_i=0x12A4 while bcd_o=0x0007 -> load_err_o pulses for 1 cycle, bcd_o stays 0x0007. Coincident tick with run_i=1 -> 0x0008.
6. run_i=0 over 3 ticks -> 3 tick_o pulses, bcd_o constant. clear_i on the same cycle as a tick with run_i=1 -> bcd_o=0x0000, wrap_o=0. BOTH_EDGES=1 variant: one full slow_clk_i period -> 2 increments.

Source files
------------

// File: rtl/slow_tick_bcd_counter.sv
// slow_tick_bcd_counter
// Turns the slow square wave from the clock divider into count ticks and
// drives a DIGITS-wide BCD up/down counter for the display.
// slow_clk_i is treated purely as data: it passes through a three-flop
// synchroniser into the clk_i domain and is then edge-detected.
//
// Ports:
//   clk_i       system clock (100 MHz)
//   rst_i       synchronous, active-high reset (highest priority)
//   slow_clk_i  slow square wave, asynchronous to clk_i
//   run_i       1 = accepted ticks advance the counter
//   up_i        1 = count up, 0 = count down (sampled on the tick cycle)
//   load_i      one-cycle pulse, loads load_val_i if every digit is <= 9
//   load_val_i  BCD load value, digit i at bits [4i+3:4i]
//   clear_i     one-cycle pulse, forces the count to zero
//   bcd_o       registered BCD count
//   tick_o      one-cycle pulse per accepted slow_clk_i edge
//   wrap_o      one-cycle pulse on full-range wrap (max->0 up, 0->max down)
//   load_err_o  one-cycle pulse when a load carried a non-BCD digit
module slow_tick_bcd_counter #(
    parameter int DIGITS     = 4,
    parameter bit BOTH_EDGES = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slow_clk_i,
    input  logic                  run_i,
    input  logic                  up_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  tick_o,
    output logic                  wrap_o,
    output logic                  load_err_o
);

    localparam int W = 4 * DIGITS;

    // True when every nibble of v is a legal BCD digit.
    function automatic logic bcd_is_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & (v[4*i +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // One BCD step up or down with ripple carry/borrow. The MSB of the
    // result is the carry/borrow out of the top digit, i.e. a full wrap.
    function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                        c           = 1'b1;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                        c           = 1'b1;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c           = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return {c, r};
    endfunction

    logic         s1_r, s2_r, s3_r;
    logic [1:0]   arm_cnt_r;
    logic [W-1:0] bcd_r;
    logic         tick_r, wrap_r, load_err_r;

    logic         edge_s, armed_s, tick_s;
    logic [W:0]   step_s;
    logic [W-1:0] bcd_next_s;
    logic         wrap_next_s, err_next_s;

    // Edge detection on the synchronised wave, masked until armed so a
    // wave already high at reset release is not mistaken for an edge.
    always_comb begin
        edge_s  = 1'b0;
        armed_s = (arm_cnt_r == 2'd3);
        if (BOTH_EDGES) begin
            edge_s = s2_r ^ s3_r;
        end else begin
            edge_s = s2_r & ~s3_r;
        end
        tick_s = edge_s & armed_s;
    end

    // Next count: clear beats a valid load, which beats counting. A
    // rejected load still lets a coincident tick count.
    always_comb begin
        bcd_next_s  = bcd_r;
        wrap_next_s = 1'b0;
        err_next_s  = 1'b0;
        step_s      = bcd_step(bcd_r, up_i);
        if (clear_i) begin
            bcd_next_s = {W{1'b0}};
        end else if (load_i && bcd_is_valid(load_val_i)) begin
            bcd_next_s = load_val_i;
        end else begin
            err_next_s = load_i;
            if (tick_s && run_i) begin
                bcd_next_s  = step_s[W-1:0];
                wrap_next_s = step_s[W];
            end else begin
                bcd_next_s = bcd_r;
            end
        end
    end

    // Synchroniser, arm counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            s3_r       <= 1'b0;
            arm_cnt_r  <= 2'd0;
            bcd_r      <= {W{1'b0}};
            tick_r     <= 1'b0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            s1_r       <= slow_clk_i;
            s2_r       <= s1_r;
            s3_r       <= s2_r;
            if (arm_cnt_r != 2'd3) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end
            bcd_r      <= bcd_next_s;
            tick_r     <= tick_s;
            wrap_r     <= wrap_next_s;
            load_err_r <= err_next_s;
        end
    end

    assign bcd_o      = bcd_r;
    assign tick_o     = tick_r;
    assign wrap_o     = wrap_r;
    assign load_err_o = load_err_r;

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Self-checking bench for slow_tick_bcd_counter: one instance counting
// rising edges only and one counting both edges, both compared each cycle
// against an integer-valued reference model, plus directed scenario checks.
module tb_slow_tick_bcd_counter;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic        clk = 1'b0;
    logic        rst_i, slow_clk_i, run_i, up_i, load_i, clear_i;
    logic [15:0] load_val_i;
    logic [15:0] bcd_a, bcd_b;
    logic        tick_a, tick_b, wrap_a, wrap_b, err_a, err_b;

    always #5 clk = ~clk;

    slow_tick_bcd_counter #(.DIGITS(DIGITS), .BOTH_EDGES(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .slow_clk_i(slow_clk_i), .run_i(run_i),
        .up_i(up_i), .load_i(load_i), .load_val_i(load_val_i), .clear_i(clear_i),
        .bcd_o(bcd_a), .tick_o(tick_a), .wrap_o(wrap_a), .load_err_o(err_a));

    slow_tick_bcd_counter #(.DIGITS(DIGITS), .BOTH_EDGES(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .slow_clk_i(slow_clk_i), .run_i(run_i),
        .up_i(up_i), .load_i(load_i), .load_val_i(load_val_i), .clear_i(clear_i),
        .bcd_o(bcd_b), .tick_o(tick_b), .wrap_o(wrap_b), .load_err_o(err_b));

    int checks   = 0;
    int failures = 0;
    int n_tick_a = 0;
    int n_wrap_a = 0;

    // Reference model state, index 0 = rising-only, 1 = both edges.
    int m_cnt[2];
    int m_since[2];
    bit m_h1[2], m_h2[2], m_h3[2];
    bit m_tick[2], m_wrap[2], m_err[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input logic [15:0] v);
        bit ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Advance the model by one clk edge using the currently driven inputs.
    // A tick at this edge comes from the slow samples taken two and three
    // edges earlier; edges in the first three cycles after reset are ignored.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit ev;
            if (rst_i) begin
                m_cnt[m] = 0; m_since[m] = 0;
                m_h1[m] = 1'b0; m_h2[m] = 1'b0; m_h3[m] = 1'b0;
                m_tick[m] = 1'b0; m_wrap[m] = 1'b0; m_err[m] = 1'b0;
            end else begin
                ev = (m == 0) ? (m_h2[m] && !m_h3[m]) : (m_h2[m] != m_h3[m]);
                ev = ev && (m_since[m] >= 3);
                m_tick[m] = ev; m_wrap[m] = 1'b0; m_err[m] = 1'b0;
                if (clear_i) begin
                    m_cnt[m] = 0;
                end else if (load_i && bcd_ok(load_val_i)) begin
                    m_cnt[m] = bcd2int(load_val_i);
                end else begin
                    m_err[m] = load_i;
                    if (ev && run_i) begin
                        if (up_i) begin
                            if (m_cnt[m] == MAXV) begin m_cnt[m] = 0; m_wrap[m] = 1'b1; end
                            else m_cnt[m] = m_cnt[m] + 1;
                        end else begin
                            if (m_cnt[m] == 0) begin m_cnt[m] = MAXV; m_wrap[m] = 1'b1; end
                            else m_cnt[m] = m_cnt[m] - 1;
                        end
                    end
                end
                if (m_since[m] < 3) m_since[m] = m_since[m] + 1;
                m_h3[m] = m_h2[m]; m_h2[m] = m_h1[m]; m_h1[m] = slow_clk_i;
            end
        end
    endtask

    // One clock: predict, let the edge happen, compare just after it, then
    // return at the falling edge so the caller can drive the next inputs.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("bcd_a",  32'(bcd_a),  32'(int2bcd(m_cnt[0])));
        check_eq("tick_a", 32'(tick_a), 32'(m_tick[0]));
        check_eq("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
        check_eq("err_a",  32'(err_a),  32'(m_err[0]));
        check_eq("bcd_b",  32'(bcd_b),  32'(int2bcd(m_cnt[1])));
        check_eq("tick_b", 32'(tick_b), 32'(m_tick[1]));
        check_eq("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
        check_eq("err_b",  32'(err_b),  32'(m_err[1]));
        if (tick_a) n_tick_a++;
        if (wrap_a) n_wrap_a++;
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        load_i = 1'b1; load_val_i = v;
        cycle();
        load_i = 1'b0;
    endtask

    task automatic pulse_slow();
        slow_clk_i = 1'b1; hold(5);
        slow_clk_i = 1'b0; hold(5);
    endtask

    initial begin
        int rem;
        rst_i = 1'b1; slow_clk_i = 1'b1; run_i = 1'b1; up_i = 1'b1;
        load_i = 1'b0; clear_i = 1'b0; load_val_i = 16'h0000;
        hold(3);
        check_eq("reset_bcd", 32'(bcd_a), 32'h0);

        // 1: released with the wave already high -> no tick
        rst_i = 1'b0; n_tick_a = 0;
        hold(20);
        check_eq("arm_no_tick", 32'(n_tick_a), 32'd0);
        check_eq("arm_bcd", 32'(bcd_a), 32'h0);
        slow_clk_i = 1'b0; hold(5);
        slow_clk_i = 1'b1; hold(5);
        check_eq("arm_first_tick", 32'(n_tick_a), 32'd1);
        slow_clk_i = 1'b0; hold(10);

        // 2: latency and four up-counts
        load_i = 1'b0; clear_i = 1'b1; cycle(); clear_i = 1'b0;
        n_tick_a = 0;
        slow_clk_i = 1'b1; hold(2);
        check_eq("lat_before", 32'(bcd_a), 32'h0);
        hold(1);
        check_eq("lat_after", 32'(bcd_a), 32'h1);
        hold(7);
        slow_clk_i = 1'b0; hold(10);
        for (int i = 0; i < 3; i++) begin
            slow_clk_i = 1'b1; hold(10);
            slow_clk_i = 1'b0; hold(10);
        end
        check_eq("up4_bcd", 32'(bcd_a), 32'h0004);
        check_eq("up4_ticks", 32'(n_tick_a), 32'd4);

        // 3: full-range wraps
        do_load(16'h9998); n_wrap_a = 0;
        pulse_slow();
        check_eq("to_9999", 32'(bcd_a), 32'h9999);
        check_eq("no_wrap_yet", 32'(n_wrap_a), 32'd0);
        pulse_slow();
        check_eq("wrap_up_bcd", 32'(bcd_a), 32'h0000);
        check_eq("wrap_up_cnt", 32'(n_wrap_a), 32'd1);
        up_i = 1'b0;
        pulse_slow();
        check_eq("wrap_dn_bcd", 32'(bcd_a), 32'h9999);
        check_eq("wrap_dn_cnt", 32'(n_wrap_a), 32'd2);

        // 4: multi-digit carry and borrow
        up_i = 1'b1; do_load(16'h1299); n_wrap_a = 0;
        pulse_slow();
        check_eq("carry", 32'(bcd_a), 32'h1300);
        up_i = 1'b0; do_load(16'h0100);
        pulse_slow();
        check_eq("borrow", 32'(bcd_a), 32'h0099);
        check_eq("no_wrap", 32'(n_wrap_a), 32'd0);

        // 5: rejected load coinciding with a tick
        up_i = 1'b1; do_load(16'h0007);
        slow_clk_i = 1'b1; hold(2);
        load_i = 1'b1; load_val_i = 16'h12A4;
        cycle();
        load_i = 1'b0;
        check_eq("bad_load_cnt", 32'(bcd_a), 32'h0008);
        check_eq("bad_load_err", 32'(err_a), 32'd1);
        cycle();
        check_eq("err_one_cycle", 32'(err_a), 32'd0);
        hold(2); slow_clk_i = 1'b0; hold(5);

        // 6: run_i=0 freezes, clear beats a tick, both-edge variant
        run_i = 1'b0; n_tick_a = 0;
        for (int i = 0; i < 3; i++) pulse_slow();
        check_eq("frozen_ticks", 32'(n_tick_a), 32'd3);
        check_eq("frozen_bcd", 32'(bcd_a), 32'h0008);
        run_i = 1'b1; do_load(16'h9999);
        slow_clk_i = 1'b1; hold(2);
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        check_eq("clr_bcd", 32'(bcd_a), 32'h0);
        check_eq("clr_wrap", 32'(wrap_a), 32'd0);
        hold(2); slow_clk_i = 1'b0; hold(5);
        do_load(16'h0000);
        pulse_slow();
        check_eq("both_edges", 32'(bcd_b), 32'h0002);

        // mid-run reset
        do_load(16'h4321);
        rst_i = 1'b1; cycle();
        check_eq("mid_rst", 32'(bcd_a), 32'h0);
        rst_i = 1'b0;

        // randomized run against the model
        rem = 5;
        for (int c = 0; c < 3000; c++) begin
            if (rem == 0) begin
                slow_clk_i = ~slow_clk_i;
                rem = int'($urandom_range(3, 12));
            end
            rem--;
            run_i   = ($urandom_range(0, 7) != 0);
            up_i    = $urandom_range(0, 1) == 1;
            rst_i   = ($urandom_range(0, 299) == 0);
            clear_i = ($urandom_range(0, 39) == 0);
            load_i  = !clear_i && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) begin
                for (int d = 0; d < DIGITS; d++) load_val_i[4*d +: 4] = 4'($urandom_range(0, 9));
            end else begin
                load_val_i = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) load_val_i = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
